systolic_ws_stream: RTL and testbench
=====================================

# systolic_ws_stream

Parametrised weight-stationary systolic array of M×N signed MAC PEs with built-in weight-load FSM, input wavefront skew, output deskew, and valid/ready handshakes with global stall on backpressure. It replaces hand-skewed feeding and per-column accumulator drain: callers present unskewed activation vectors and receive one aligned N-wide result vector per input vector. Sits between the activation buffer (upstream) and the result writeback (downstream) in the accelerator datapath.

## Interface
- M, default 4: PE rows (reduction length); must be ≥ 1.
- N, default 4: PE columns (output channels); must be ≥ 1.
- A_W, default 8: signed weight width.
- B_W, default 8: signed activation width.
- C_W, default 32: signed psum/result width; must be ≥ A_W+B_W.
- clk, in, 1: single clock; all state updates on the rising edge.
- rst, in, 1: asynchronous, active-low reset.
- w_valid, in, 1: weight row valid.
- w_ready, out, 1: weight row accepted when w_valid && w_ready.
- w_row, in, N*A_W: weight row r; column j is at bits [j*A_W +: A_W].
- a_valid, in, 1: activation vector valid.
- a_ready, out, 1: vector accepted when a_valid && a_ready.
- a_vec, in, M*B_W: activation element i is at bits [i*B_W +: B_W].
- a_last, in, 1: marks the final vector of a run; sampled on accept.
- relu_en, in, 1: clamps negative results to 0; held static while busy=1.
- out_valid, out, 1: result vector valid.
- out_ready, in, 1: result consumed when out_valid && out_ready.
- out_vec, out, N*C_W: result column j is at bits [j*C_W +: C_W].
- out_last, out, 1: result belongs to the a_last vector.
- busy, out, 1: high in STREAM or DRAIN.

## Operation
- FSM states: IDLE, LOAD, STREAM, DRAIN.
- IDLE:
  - w_ready=1.
  - On w accept: write row 0, clear w_loaded, go to LOAD. If M=1, set w_loaded and stay in IDLE.
  - a_ready=w_loaded.
  - On a accept: go to STREAM, or to DRAIN if a_last=1.
- LOAD:
  - w_ready=1; a_ready=0.
  - Each w accept writes row w_cnt, where w_cnt counts 1..M-1.
  - After row M-1 is written: set w_loaded, go to IDLE.
- STREAM:
  - w_ready=0.
  - a_ready=en (the advance enable, see Timing).
  - On accept with a_last=1: go to DRAIN.
- DRAIN:
  - a_ready=0; w_ready=0.
  - When the out_last beat is consumed: go to IDLE.
  - Weights are retained, so a new run needs no reload.
- Computation: out_vec[j] = Σ_{i=0..M-1} a[i]·W[i][j].
  - Products and sums are signed two's complement.
  - Products are sign-extended to C_W; sums wrap modulo 2^C_W.
  - If relu_en=1 and the result MSB is 1, the column outputs 0.
- Structure:
  - Activation element i passes through an i-stage skew, then one register per PE eastward.
  - Psum registers run one per PE southward, with a zero bias at the top.
  - Column j result passes through an (N-1-j)-stage deskew.
  - A valid/last tag pipeline of depth M+N tracks each vector. Cycles with no accept inject a zero vector tagged invalid.
- Results leave strictly in acceptance order; none are lost or duplicated.

## Timing
- Reset (rst=0), asynchronous:
  - state=IDLE, w_cnt=0, w_loaded=0.
  - All weight, skew, psum, deskew and tag registers are 0.
  - Outputs: out_valid=0, out_last=0, out_vec=0, busy=0, a_ready=0, w_ready=1.
- Latency: with no stall, a vector accepted on edge k appears with out_valid=1 after edge k+M+N, i.e. M+N cycles.
- Throughput: one vector per cycle.
- Advance enable: en = !(out_valid && !out_ready).
  - When en=0, every pipeline, skew, deskew and tag register holds, and a_ready=0.
  - out_vec, out_valid and out_last stay stable until consumed.
- Bubbles: out_valid=0 cycles while en=1 simply advance the pipeline.
- Weight writes take effect on the accepting edge and are never concurrent with streaming.
- Reset asserted mid-stream: all in-flight results are discarded, no out_valid is produced, and weights must be reloaded.
- w_valid while busy: ignored (w_ready=0), with no side effects.

## Test plan
- Reset: hold rst=0 for 3 cycles, then release → out_valid=0, a_ready=0, w_ready=1, busy=0.
- Identity (M=N=4):
  - Stimulus: load W=I, then stream a=(1,2,3,4) with a_last=1.
  - Response: out_vec=(1,2,3,4), out_valid exactly 8 cycles after accept, out_last=1, then busy=0.
- Signed extremes:
  - W all -128, a all -128 → each column = 65536.
  - W all 1, a all -1 → each column = -4 (0xFFFFFFFC); with relu_en=1 → each column = 0.
- Backpressure:
  - Stream 16 back-to-back vectors a=(n,0,0,0) with W[0][j]=j+1; toggle out_ready with a random pattern.
  - Response: results (n·1, n·2, n·3, n·4) in order, exactly 16 beats; a_ready=0 in every stall cycle.
- Re-run without reload:
  - After the first run completes, stream a second run.
  - Response: w_ready=0 throughout busy; the second run uses the original weights.
- Mid-stream reset:
  - Assert rst=0 after 3 accepts.
  - Response: out_valid=0 immediately; after release, a_ready=0 until M weight rows are reloaded.

Source files
------------

// File: rtl/systolic_ws_stream.sv
// Weight-stationary M x N signed MAC array with row-serial weight loading,
// wavefront skew/deskew and a stall-everything valid/ready stream interface.
module systolic_ws_stream #(
    parameter int M   = 4,
    parameter int N   = 4,
    parameter int A_W = 8,
    parameter int B_W = 8,
    parameter int C_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               w_valid,
    output logic               w_ready,
    input  logic [N*A_W-1:0]   w_row,
    input  logic               a_valid,
    output logic               a_ready,
    input  logic [M*B_W-1:0]   a_vec,
    input  logic               a_last,
    input  logic               relu_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*C_W-1:0]   out_vec,
    output logic               out_last,
    output logic               busy
);

    localparam int CNT_W = (M > 1) ? $clog2(M) : 1;
    localparam int TAG_D = M + N;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  w_cnt_reg;
    logic              w_loaded_reg;
    logic              en, w_fire, a_fire, last_row;

    logic signed [B_W-1:0] row_west   [M];
    logic signed [B_W-1:0] act_east   [M][N];
    logic signed [C_W-1:0] psum_south [M][N];
    logic signed [C_W-1:0] col_out    [N];

    logic [TAG_D-1:0]  tag_valid_reg, tag_last_reg;
    logic              out_valid_reg, out_last_reg;

    // A result held for a stalled consumer freezes the whole array.
    assign en        = !(out_valid_reg && !out_ready);
    assign w_fire    = w_valid && w_ready;
    assign a_fire    = a_valid && a_ready;
    assign last_row  = (w_cnt_reg == CNT_W'(M - 1));
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (a_fire) begin
                    state_next = a_last ? DRAIN : STREAM;
                end else if (w_fire && !last_row) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (w_fire && last_row) begin
                    state_next = IDLE;
                end
            end
            STREAM: begin
                if (a_fire && a_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (out_valid_reg && out_ready && out_last_reg) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A weight offer in IDLE starts a reload, so it blocks a same-cycle run start.
    always_comb begin
        w_ready = 1'b0;
        a_ready = 1'b0;
        busy    = 1'b0;
        case (state_reg)
            IDLE: begin
                w_ready = 1'b1;
                a_ready = w_loaded_reg && !w_valid && en;
            end
            LOAD: begin
                w_ready = 1'b1;
            end
            STREAM: begin
                a_ready = en;
                busy    = 1'b1;
            end
            DRAIN: begin
                busy    = 1'b1;
            end
            default: begin
                busy    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_cnt_reg    <= '0;
            w_loaded_reg <= 1'b0;
        end else if (w_fire) begin
            if (last_row) begin
                w_cnt_reg    <= '0;
                w_loaded_reg <= 1'b1;
            end else begin
                w_cnt_reg    <= w_cnt_reg + 1'b1;
                w_loaded_reg <= 1'b0;
            end
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < M; gi++) begin : g_row
            logic signed [B_W-1:0] a_in;

            // Idle cycles push a zero vector so the wavefront keeps moving.
            assign a_in = a_fire ? a_vec[gi*B_W +: B_W] : '0;

            if (gi == 0) begin : g_noskew
                assign row_west[gi] = a_in;
            end else begin : g_skew
                logic signed [B_W-1:0] skew_reg [gi];

                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        for (int s = 0; s < gi; s++) begin
                            skew_reg[s] <= '0;
                        end
                    end else if (en) begin
                        skew_reg[0] <= a_in;
                        for (int s = 1; s < gi; s++) begin
                            skew_reg[s] <= skew_reg[s-1];
                        end
                    end
                end

                assign row_west[gi] = skew_reg[gi-1];
            end

            for (gj = 0; gj < N; gj++) begin : g_pe
                logic signed [A_W-1:0] wt_reg;
                logic signed [B_W-1:0] act_reg;
                logic signed [B_W-1:0] act_west;
                logic signed [C_W-1:0] psum_reg;
                logic signed [C_W-1:0] psum_north;
                logic signed [C_W-1:0] prod;

                if (gj == 0) begin : g_west_edge
                    assign act_west = row_west[gi];
                end else begin : g_west_pe
                    assign act_west = act_east[gi][gj-1];
                end

                if (gi == 0) begin : g_north_edge
                    assign psum_north = '0;
                end else begin : g_north_pe
                    assign psum_north = psum_south[gi-1][gj];
                end

                // Operands are sign-extended first so the sum wraps at C_W bits.
                assign prod = C_W'(act_reg) * C_W'(wt_reg);

                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        wt_reg <= '0;
                    end else if (w_fire && (w_cnt_reg == CNT_W'(gi))) begin
                        wt_reg <= w_row[gj*A_W +: A_W];
                    end
                end

                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        act_reg  <= '0;
                        psum_reg <= '0;
                    end else if (en) begin
                        act_reg  <= act_west;
                        psum_reg <= psum_north + prod;
                    end
                end

                assign act_east[gi][gj]   = act_reg;
                assign psum_south[gi][gj] = psum_reg;
            end
        end

        for (gj = 0; gj < N; gj++) begin : g_col
            localparam int DSK = N - 1 - gj;
            logic signed [C_W-1:0] res_reg;

            if (DSK == 0) begin : g_nodsk
                assign col_out[gj] = psum_south[M-1][gj];
            end else begin : g_dsk
                logic signed [C_W-1:0] dsk_reg [DSK];

                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        for (int s = 0; s < DSK; s++) begin
                            dsk_reg[s] <= '0;
                        end
                    end else if (en) begin
                        dsk_reg[0] <= psum_south[M-1][gj];
                        for (int s = 1; s < DSK; s++) begin
                            dsk_reg[s] <= dsk_reg[s-1];
                        end
                    end
                end

                assign col_out[gj] = dsk_reg[DSK-1];
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    res_reg <= '0;
                end else if (en) begin
                    res_reg <= (relu_en && col_out[gj][C_W-1]) ? '0 : col_out[gj];
                end
            end

            assign out_vec[gj*C_W +: C_W] = res_reg;
        end
    endgenerate

    // Tag pipeline matches the skew + array + deskew depth exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_valid_reg <= '0;
            tag_last_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end else if (en) begin
            tag_valid_reg <= {tag_valid_reg[TAG_D-2:0], a_fire};
            tag_last_reg  <= {tag_last_reg[TAG_D-2:0], a_fire && a_last};
            out_valid_reg <= tag_valid_reg[TAG_D-1];
            out_last_reg  <= tag_last_reg[TAG_D-1];
        end
    end

endmodule

// File: tb/tb_systolic_ws_stream.sv
// Directed bench for systolic_ws_stream (4x4, 8-bit operands, 32-bit results).
`timescale 1ns/1ps
module tb_systolic_ws_stream;

    localparam int M   = 4;
    localparam int N   = 4;
    localparam int A_W = 8;
    localparam int B_W = 8;
    localparam int C_W = 32;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               w_valid = 1'b0;
    logic               w_ready;
    logic [N*A_W-1:0]   w_row = '0;
    logic               a_valid = 1'b0;
    logic               a_ready;
    logic [M*B_W-1:0]   a_vec = '0;
    logic               a_last = 1'b0;
    logic               relu_en = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [N*C_W-1:0]   out_vec;
    logic               out_last;
    logic               busy;

    systolic_ws_stream #(
        .M(M), .N(N), .A_W(A_W), .B_W(B_W), .C_W(C_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_row     (w_row),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_vec     (a_vec),
        .a_last    (a_last),
        .relu_en   (relu_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [N*A_W-1:0] pw(input int c0, input int c1, input int c2, input int c3);
        logic [N*A_W-1:0] r;
        int v[4];
        v = '{c0, c1, c2, c3};
        for (int j = 0; j < 4; j++) r[j*A_W +: A_W] = A_W'(v[j]);
        return r;
    endfunction

    function automatic logic [M*B_W-1:0] pa(input int c0, input int c1, input int c2, input int c3);
        logic [M*B_W-1:0] r;
        int v[4];
        v = '{c0, c1, c2, c3};
        for (int j = 0; j < 4; j++) r[j*B_W +: B_W] = B_W'(v[j]);
        return r;
    endfunction

    function automatic logic [N*C_W-1:0] po(input int c0, input int c1, input int c2, input int c3);
        logic [N*C_W-1:0] r;
        int v[4];
        v = '{c0, c1, c2, c3};
        for (int j = 0; j < 4; j++) r[j*C_W +: C_W] = C_W'(v[j]);
        return r;
    endfunction

    logic [N*A_W-1:0] wrows [4];
    logic [M*B_W-1:0] vq [$];
    logic [N*C_W:0]   exp_q [$];

    // Output monitor: scoreboards every consumed beat and the stall/busy rules.
    int   beats = 0;
    int   first_valid_cyc = -1;
    logic mon_prev_valid = 1'b0;
    always @(negedge clk) begin
        logic [N*C_W:0] e;
        #2;
        if (rst) begin
            if (out_valid && !mon_prev_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && out_ready) begin
                check_val("beat_expected", 128'(exp_q.size() > 0), 128'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_val("out_vec", out_vec, e[N*C_W-1:0]);
                    check_val("out_last", 128'(out_last), 128'(e[N*C_W]));
                end
                $display("beat %0d cyc %0d vec=%h last=%b", beats, cyc, out_vec, out_last);
                beats++;
            end
            if (out_valid && !out_ready) check_val("stall_a_ready", 128'(a_ready), 128'(0));
            if (busy) check_val("busy_w_ready", 128'(w_ready), 128'(0));
        end
        mon_prev_valid = out_valid;
    end

    task automatic load_w(input int first, input int cnt);
        for (int r = first; r < first + cnt; r++) begin
            int t = 0;
            @(negedge clk);
            w_valid = 1'b1;
            w_row   = wrows[r];
            while (!w_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            check_val("w_ready_load", 128'(w_ready), 128'(1));
            @(posedge clk);
        end
        @(negedge clk);
        w_valid = 1'b0;
    endtask

    task automatic run_stream(input bit bp, input bit w_noise, output int acc_first, output int acc_last);
        int idx = 0;
        int t = 0;
        int nvec;
        int target;
        nvec = vq.size();
        target = beats + nvec;
        acc_first = -1;
        acc_last = -1;
        while ((idx < nvec || beats < target) && t < 400) begin
            @(negedge clk);
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            w_valid   = w_noise && busy;
            w_row     = pw(127, -1, 127, -1);
            a_valid   = (idx < nvec);
            a_vec     = (idx < nvec) ? vq[idx] : '0;
            a_last    = (idx == nvec - 1);
            #1;
            if (a_valid && a_ready) begin
                if (idx == 0) acc_first = cyc + 1;
                acc_last = cyc + 1;
                idx++;
            end
            t++;
        end
        @(negedge clk);
        a_valid = 1'b0;
        a_last = 1'b0;
        w_valid = 1'b0;
        out_ready = 1'b1;
        check_val("stream_in_time", 128'(t < 400), 128'(1));
        t = 0;
        while (busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_val("busy_after_run", 128'(busy), 128'(0));
        check_val("beat_count", 128'(beats), 128'(target));
        vq.delete();
    endtask

    initial begin
        int f0, l0, acc, t;
        #400000;
        $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
        $fatal(1);
    end

    initial begin
        int f0, l0, acc, t;

        // Reset
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("rst_out_valid", 128'(out_valid), 128'(0));
        check_val("rst_a_ready", 128'(a_ready), 128'(0));
        check_val("rst_w_ready", 128'(w_ready), 128'(1));
        check_val("rst_busy", 128'(busy), 128'(0));
        check_val("rst_out_vec", out_vec, '0);
        check_val("rst_out_last", 128'(out_last), 128'(0));

        // Identity weights, latency M+N
        wrows = '{pw(1,0,0,0), pw(0,1,0,0), pw(0,0,1,0), pw(0,0,0,1)};
        load_w(0, 4);
        vq.push_back(pa(1, 2, 3, 4));
        exp_q.push_back({1'b1, po(1, 2, 3, 4)});
        first_valid_cyc = -1;
        run_stream(1'b0, 1'b0, f0, l0);
        check_val("latency", 128'(first_valid_cyc - f0), 128'(8));

        // Signed extremes
        wrows = '{pw(-128,-128,-128,-128), pw(-128,-128,-128,-128),
                  pw(-128,-128,-128,-128), pw(-128,-128,-128,-128)};
        load_w(0, 4);
        vq.push_back(pa(-128, -128, -128, -128));
        exp_q.push_back({1'b1, po(65536, 65536, 65536, 65536)});
        run_stream(1'b0, 1'b0, f0, l0);

        wrows = '{pw(1,1,1,1), pw(1,1,1,1), pw(1,1,1,1), pw(1,1,1,1)};
        load_w(0, 4);
        vq.push_back(pa(-1, -1, -1, -1));
        exp_q.push_back({1'b1, po(-4, -4, -4, -4)});
        run_stream(1'b0, 1'b0, f0, l0);

        relu_en = 1'b1;
        vq.push_back(pa(-1, -1, -1, -1));
        vq.push_back(pa(1, 2, 3, 4));
        exp_q.push_back({1'b0, po(0, 0, 0, 0)});
        exp_q.push_back({1'b1, po(10, 10, 10, 10)});
        run_stream(1'b0, 1'b0, f0, l0);
        relu_en = 1'b0;

        // Backpressure: 16 vectors with random consumer stalls
        wrows = '{pw(1,2,3,4), pw(1,1,1,1), pw(0,0,0,0), pw(0,0,0,0)};
        load_w(0, 4);
        for (int n = 1; n <= 16; n++) begin
            vq.push_back(pa(n, 0, 0, 0));
            exp_q.push_back({(n == 16), po(n, 2*n, 3*n, 4*n)});
        end
        run_stream(1'b1, 1'b0, f0, l0);

        // Second run without reload, weight offers while busy must be ignored
        vq.push_back(pa(2, 3, 0, 0));
        vq.push_back(pa(1, 1, 0, 0));
        exp_q.push_back({1'b0, po(5, 7, 9, 11)});
        exp_q.push_back({1'b1, po(2, 3, 4, 5)});
        run_stream(1'b0, 1'b1, f0, l0);
        check_val("back_to_back", 128'(l0 - f0), 128'(1));
        vq.push_back(pa(1, 0, 0, 0));
        exp_q.push_back({1'b1, po(1, 2, 3, 4)});
        run_stream(1'b0, 1'b0, f0, l0);

        // Mid-stream reset
        acc = 0;
        t = 0;
        while (acc < 3 && t < 20) begin
            @(negedge clk);
            out_ready = 1'b0;
            a_valid = 1'b1;
            a_vec = pa(1, 1, 1, 1);
            a_last = 1'b0;
            #1;
            if (a_ready) acc++;
            t++;
        end
        check_val("mid_accepts", 128'(acc), 128'(3));
        @(negedge clk);
        a_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check_val("mid_stalled_valid", 128'(out_valid), 128'(1));
        #3;
        rst = 1'b0;
        #1;
        check_val("mid_rst_out_valid", 128'(out_valid), 128'(0));
        check_val("mid_rst_busy", 128'(busy), 128'(0));
        check_val("mid_rst_out_vec", out_vec, '0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            out_ready = 1'b1;
            a_valid = 1'b1;
            a_vec = pa(5, 5, 5, 5);
            #1;
            check_val("post_rst_a_ready", 128'(a_ready), 128'(0));
            check_val("post_rst_out_valid", 128'(out_valid), 128'(0));
        end
        @(negedge clk);
        a_valid = 1'b0;
        wrows = '{pw(1,0,0,0), pw(0,1,0,0), pw(0,0,1,0), pw(0,0,0,1)};
        load_w(0, 3);
        @(negedge clk);
        a_valid = 1'b1;
        #1;
        check_val("partial_load_a_ready", 128'(a_ready), 128'(0));
        a_valid = 1'b0;
        load_w(3, 1);
        @(negedge clk);
        a_valid = 1'b1;
        #1;
        check_val("reloaded_a_ready", 128'(a_ready), 128'(1));
        a_valid = 1'b0;
        vq.push_back(pa(9, 8, 7, 6));
        exp_q.push_back({1'b1, po(9, 8, 7, 6)});
        run_stream(1'b0, 1'b0, f0, l0);
        check_val("exp_queue_drained", 128'(exp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
